// File: rtl/free_reg_list.sv
// Free physical-register list: circular FIFO of unmapped phys reg IDs handed to rename, refilled by retire.
// Optional FRL_DOUBLE_FREE_CHECK_EN adds an in-list vector that drops duplicate returns and flags err_double_free.
module free_reg_list #(
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned NUM_ARCH_REGS = 32,
  localparam int unsigned PW    = $clog2(NUM_PHYS_REGS),
  localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          frl_valid,
  output logic [PW-1:0] free_register_data,
  input  logic          frl_ready,
  input  logic          ret_valid,
  input  logic [PW-1:0] ret_reg,
  output logic          ret_ready,
  output logic [CW-1:0] free_count,
  output logic          err_overflow
`ifdef FRL_DOUBLE_FREE_CHECK_EN
  ,
  output logic          err_double_free
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_err_overflow;
  logic          w_alloc;
  logic          w_ret_try;
  logic          w_ret;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign frl_valid          = (r_count != '0);
  assign free_register_data = r_mem[r_head];
  assign free_count         = r_count;
  assign err_overflow       = r_err_overflow;
  assign w_alloc            = frl_valid & frl_ready;
  assign ret_ready          = (r_count < CW'(DEPTH)) | w_alloc;
  assign w_ret_try          = ret_valid & ret_ready;

`ifdef FRL_DOUBLE_FREE_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] r_in_list;
  logic                     r_err_double_free;
  logic                     w_dup;

  // An ID leaving via alloc in the same cycle is no longer considered in the list.
  assign w_dup           = r_in_list[ret_reg] & ~(w_alloc & (free_register_data == ret_reg));
  assign w_ret           = w_ret_try & ~w_dup;
  assign err_double_free = r_err_double_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PHYS_REGS; i++)
        r_in_list[PW'(i)] <= (i >= NUM_ARCH_REGS);
      r_err_double_free <= 1'b0;
    end else begin
      if (w_alloc) r_in_list[free_register_data] <= 1'b0;
      if (w_ret) r_in_list[ret_reg] <= 1'b1;
      if (w_ret_try & w_dup) r_err_double_free <= 1'b1;
    end
  end
`else
  assign w_ret = w_ret_try;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        r_mem[AW'(i)] <= PW'(NUM_ARCH_REGS + i);
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= CW'(DEPTH);
      r_err_overflow <= 1'b0;
    end else begin
      if (w_alloc) r_head <= ptr_inc(r_head);
      if (w_ret) begin
        r_mem[r_tail] <= ret_reg;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_ret & ~w_alloc)
        r_count <= r_count + CW'(1);
      else if (w_alloc & ~w_ret)
        r_count <= r_count - CW'(1);
      if (ret_valid & ~ret_ready) r_err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_reg_list.sv
// Bench for free_reg_list: directed scenarios plus random traffic against a queue-based model of the free pool.
module tb_free_reg_list;

  localparam int unsigned NPR   = 64;
  localparam int unsigned NAR   = 32;
  localparam int unsigned DEPTH = NPR - NAR;
  localparam int unsigned PW    = $clog2(NPR);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frl_valid;
  logic [PW-1:0] free_register_data;
  logic          frl_ready = 1'b0;
  logic          ret_valid = 1'b0;
  logic [PW-1:0] ret_reg = '0;
  logic          ret_ready;
  logic [CW-1:0] free_count;
  logic          err_overflow;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
  logic          err_double_free;
`endif

  free_reg_list #(.NUM_PHYS_REGS(NPR), .NUM_ARCH_REGS(NAR)) dut (
    .clk                (clk),
    .rst                (rst),
    .frl_valid          (frl_valid),
    .free_register_data (free_register_data),
    .frl_ready          (frl_ready),
    .ret_valid          (ret_valid),
    .ret_reg            (ret_reg),
    .ret_ready          (ret_ready),
    .free_count         (free_count),
    .err_overflow       (err_overflow)
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    ,
    .err_double_free    (err_double_free)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the pool as an ordered queue of IDs plus sticky flags.
  int m_q[$];
  bit m_ovf;
  bit m_dbl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < int'(DEPTH); i++) m_q.push_back(int'(NAR) + i);
    m_ovf = 1'b0;
    m_dbl = 1'b0;
  endtask

  task automatic check_state();
    chk("frl_valid", 32'(frl_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("data", 32'(free_register_data), 32'(m_q[0]));
    chk("free_count", 32'(free_count), 32'(m_q.size()));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    chk("err_double_free", 32'(err_double_free), 32'(m_dbl));
`endif
  endtask

  task automatic do_reset(input bit rdy, input bit rv, input int rr);
    @(negedge clk);
    rst = 1'b1; frl_ready = rdy; ret_valid = rv; ret_reg = PW'(rr);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of traffic: check registered outputs, drive, check ret_ready, advance model.
  task automatic step(input bit rdy, input bit rv, input int rr);
    bit alloc, rr_exp, found;
    @(negedge clk);
    check_state();
    frl_ready = rdy; ret_valid = rv; ret_reg = PW'(rr);
    alloc  = (m_q.size() != 0) && rdy;
    rr_exp = (m_q.size() < int'(DEPTH)) || alloc;
    #1;
    chk("ret_ready", 32'(ret_ready), 32'(rr_exp));
    if (alloc) void'(m_q.pop_front());
    if (rv) begin
      if (!rr_exp) m_ovf = 1'b1;
      else begin
        found = 1'b0;
`ifdef FRL_DOUBLE_FREE_CHECK_EN
        foreach (m_q[k]) if (m_q[k] == rr) found = 1'b1;
        if (found) m_dbl = 1'b1;
`endif
        if (!found) m_q.push_back(rr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and drain in order
    do_reset(1'b0, 1'b0, 0);
    chk("rst_valid", 32'(frl_valid), 32'd1);
    chk("rst_data", 32'(free_register_data), 32'd32);
    chk("rst_count", 32'(free_count), 32'd32);
    chk("rst_ovf", 32'(err_overflow), 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk("drain_data", 32'(free_register_data), 32'(32 + i));
      step(1'b1, 1'b0, 0);
    end
    chk("empty_valid", 32'(frl_valid), 32'd0);
    chk("empty_count", 32'(free_count), 32'd0);

    // Return into empty list: latency one, FIFO order
    step(1'b0, 1'b1, 5);
    chk("ret5_valid", 32'(frl_valid), 32'd1);
    chk("ret5_data", 32'(free_register_data), 32'd5);
    step(1'b0, 1'b1, 9);
    chk("ret9_count", 32'(free_count), 32'd2);
    step(1'b1, 1'b0, 0);
    chk("ret9_data", 32'(free_register_data), 32'd9);
    step(1'b1, 1'b0, 0);
    chk("reempty_valid", 32'(frl_valid), 32'd0);

    // Return to a full list without alloc is dropped and sticky
    do_reset(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 7);
    chk("ovf_set", 32'(err_overflow), 32'd1);
    chk("ovf_count", 32'(free_count), 32'd32);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);

    // Full list with alloc+return: accepted, 7 emerges last
    do_reset(1'b0, 1'b0, 0);
    chk("ovf_cleared", 32'(err_overflow), 32'd0);
    step(1'b1, 1'b1, 7);
    chk("full_swap_count", 32'(free_count), 32'd32);
    for (int i = 0; i < 32; i++) begin
      chk("swap_order", 32'(free_register_data), (i < 31) ? 32'(33 + i) : 32'd7);
      step(1'b1, 1'b0, 0);
    end
    chk("swap_empty", 32'(frl_valid), 32'd0);

    // Pointer wrap with alternating alloc / return
    do_reset(1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, i % 32);
    end
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 0);

`ifdef FRL_DOUBLE_FREE_CHECK_EN
    do_reset(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 40);
    chk("dbl_set", 32'(err_double_free), 32'd1);
    chk("dbl_count", 32'(free_count), 32'd31);
    step(1'b1, 1'b1, 33);
`endif

    // Reset mid-operation with traffic asserted
    step(1'b1, 1'b1, 3);
    do_reset(1'b1, 1'b1, 11);
    chk("midrst_count", 32'(free_count), 32'd32);
    chk("midrst_data", 32'(free_register_data), 32'd32);

    // Random traffic with phases biased toward empty and full
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit rdy, rv;
      ph  = (i / 150) % 3;
      rdy = (ph == 0) ? ($urandom_range(0, 9) < 8) : (ph == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1) == 1;
      rv  = (ph == 0) ? ($urandom_range(0, 9) < 2) : (ph == 1) ? ($urandom_range(0, 9) < 8) : $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 399) == 0)
        do_reset(rdy, rv, int'($urandom_range(0, NPR - 1)));
      else
        step(rdy, rv, int'($urandom_range(0, NPR - 1)));
    end
    @(negedge clk);
    check_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
